// File: rtl/rle_index_pkg.sv
// Shared types and helpers for the run-length index decoder.
//   state_t   : decoder word-class state (LIT_FIRST / LIT / RUN)
//   is_escape : true when the low `width` bits of a word are all ones
package rle_index_pkg;

  typedef enum logic [1:0] {
    ST_LIT_FIRST = 2'b00,
    ST_LIT       = 2'b01,
    ST_RUN       = 2'b10
  } state_t;

  // Widest stream word is_escape can inspect.
  localparam int MAX_W = 64;

  function automatic logic is_escape(input logic [MAX_W-1:0] word, input int unsigned width);
    logic [MAX_W-1:0] mask;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    return (word & mask) == mask;
  endfunction

endpackage

// File: rtl/rle_index_decoder_sample_edge_detect.sv
// Masked change detector for literal samples.
// Keeps the last literal seen and reports, one cycle after the accepting
// edge, the index and value of any literal whose masked bits differ from it.
//   clk, rst_n     : clock, async active-low reset
//   i_clear        : synchronous restart (same effect as reset)
//   i_lit_strobe   : an accepted literal word is on i_sample this cycle
//   i_sample       : literal value
//   i_edge_mask    : bits that take part in the compare
//   i_index        : index of this literal (pre-increment count)
//   o_edge_valid   : one-cycle pulse on a detected change
//   o_edge_index   : index of the changing literal (held)
//   o_edge_sample  : value of the changing literal (held)
module sample_edge_detect #(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_lit_strobe,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic [SAMPLE_W-1:0] i_edge_mask,
  input  logic [INDEX_W-1:0]  i_index,
  output logic                o_edge_valid,
  output logic [INDEX_W-1:0]  o_edge_index,
  output logic [SAMPLE_W-1:0] o_edge_sample
);

  logic [SAMPLE_W-1:0] r_last_lit;
  logic                r_have_prev;
  logic                r_edge_valid;
  logic [INDEX_W-1:0]  r_edge_index;
  logic [SAMPLE_W-1:0] r_edge_sample;
  logic                w_edge;

  // The first literal after a restart has nothing to compare against.
  assign w_edge = i_lit_strobe & r_have_prev & (|((i_sample ^ r_last_lit) & i_edge_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_lit    <= '0;
      r_have_prev   <= 1'b0;
      r_edge_valid  <= 1'b0;
      r_edge_index  <= '0;
      r_edge_sample <= '0;
    end else if (i_clear) begin
      r_last_lit    <= '0;
      r_have_prev   <= 1'b0;
      r_edge_valid  <= 1'b0;
      r_edge_index  <= '0;
      r_edge_sample <= '0;
    end else begin
      r_edge_valid <= w_edge;
      if (w_edge) begin
        r_edge_index  <= i_index;
        r_edge_sample <= i_sample;
      end
      if (i_lit_strobe) begin
        r_last_lit  <= i_sample;
        r_have_prev <= 1'b1;
      end
    end
  end

  assign o_edge_valid  = r_edge_valid;
  assign o_edge_index  = r_edge_index;
  assign o_edge_sample = r_edge_sample;

endmodule

// File: rtl/rle_index_decoder.sv
// Run-length-compressed sample stream decoder.
// Tracks the absolute expanded-sample index of the stream, flags index
// wrap (sticky), and reports masked value changes on literal samples.
// A literal equal to the previous word announces a run; the following word
// is then a count. An all-ones count continues the run with another count.
//   clk, rst_n      : clock, async active-low reset
//   i_clear         : synchronous restart, wins over i_sample_strobe
//   i_sample        : stream word (literal or run count)
//   i_sample_strobe : accept i_sample this cycle
//   i_edge_mask     : bits participating in edge detection
//   o_index         : expanded-sample count after the last accepted word
//   o_index_wrap    : sticky carry-out of the index adder
//   o_edge_valid    : one-cycle change pulse
//   o_edge_index    : index of the sample that changed
//   o_edge_sample   : literal value that caused the change
module rle_index_decoder
  import rle_index_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int INDEX_W  = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_strobe,
  input  logic [SAMPLE_W-1:0] i_edge_mask,
  output logic [INDEX_W-1:0]  o_index,
  output logic                o_index_wrap,
  output logic                o_edge_valid,
  output logic [INDEX_W-1:0]  o_edge_index,
  output logic [SAMPLE_W-1:0] o_edge_sample
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SAMPLE_W-1:0] r_last_word;
  logic [INDEX_W-1:0]  r_index;
  logic                r_index_wrap;
  logic                w_accept;
  logic                w_is_lit;
  logic [INDEX_W-1:0]  w_add;
  logic [INDEX_W:0]    w_sum;

  assign w_accept = i_sample_strobe & ~i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_state <= ST_LIT_FIRST;
    else if (i_clear)  r_state <= ST_LIT_FIRST;
    else if (w_accept) r_state <= w_state_nxt;
  end

  // Word classification and next state. The unused encoding falls back to
  // literal handling and restarts in LIT_FIRST.
  always_comb begin
    w_state_nxt = ST_LIT_FIRST;
    w_is_lit    = 1'b1;
    w_add       = INDEX_W'(1);
    case (r_state)
      ST_LIT_FIRST: w_state_nxt = ST_LIT;
      ST_LIT:       w_state_nxt = (i_sample == r_last_word) ? ST_RUN : ST_LIT;
      ST_RUN: begin
        w_is_lit    = 1'b0;
        w_add       = INDEX_W'(i_sample);
        w_state_nxt = is_escape(MAX_W'(i_sample), SAMPLE_W) ? ST_RUN : ST_LIT_FIRST;
      end
      default:      w_state_nxt = ST_LIT_FIRST;
    endcase
  end

  // One extra bit captures the carry for the wrap flag.
  assign w_sum = {1'b0, r_index} + {1'b0, w_add};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index      <= '0;
      r_index_wrap <= 1'b0;
      r_last_word  <= '0;
    end else if (i_clear) begin
      r_index      <= '0;
      r_index_wrap <= 1'b0;
      r_last_word  <= '0;
    end else if (w_accept) begin
      r_index      <= w_sum[INDEX_W-1:0];
      r_index_wrap <= r_index_wrap | w_sum[INDEX_W];
      r_last_word  <= i_sample;
    end
  end

  sample_edge_detect #(
    .SAMPLE_W (SAMPLE_W),
    .INDEX_W  (INDEX_W)
  ) u_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (i_clear),
    .i_lit_strobe  (w_accept & w_is_lit),
    .i_sample      (i_sample),
    .i_edge_mask   (i_edge_mask),
    .i_index       (r_index),
    .o_edge_valid  (o_edge_valid),
    .o_edge_index  (o_edge_index),
    .o_edge_sample (o_edge_sample)
  );

  assign o_index      = r_index;
  assign o_index_wrap = r_index_wrap;

endmodule

// File: tb/tb_rle_index_decoder.sv
module tb_rle_index_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_clear = 1'b0;
  logic [15:0] i_sample = '0;
  logic        i_sample_strobe = 1'b0;
  logic [15:0] i_edge_mask = '0;

  logic [47:0] o_index;
  logic        o_index_wrap;
  logic        o_edge_valid;
  logic [47:0] o_edge_index;
  logic [15:0] o_edge_sample;

  logic [15:0] s_index;
  logic        s_index_wrap;
  logic        s_edge_valid;
  logic [15:0] s_edge_index;
  logic [15:0] s_edge_sample;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic        sel16;
    logic [47:0] idx;
    logic        wrap;
    logic        ev;
    logic [47:0] ei;
    logic [15:0] es;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rle_index_decoder u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (i_clear),
    .i_sample        (i_sample),
    .i_sample_strobe (i_sample_strobe),
    .i_edge_mask     (i_edge_mask),
    .o_index         (o_index),
    .o_index_wrap    (o_index_wrap),
    .o_edge_valid    (o_edge_valid),
    .o_edge_index    (o_edge_index),
    .o_edge_sample   (o_edge_sample)
  );

  rle_index_decoder #(.SAMPLE_W(16), .INDEX_W(16)) u_dut16 (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clear         (i_clear),
    .i_sample        (i_sample),
    .i_sample_strobe (i_sample_strobe),
    .i_edge_mask     (i_edge_mask),
    .o_index         (s_index),
    .o_index_wrap    (s_index_wrap),
    .o_edge_valid    (s_edge_valid),
    .o_edge_index    (s_edge_index),
    .o_edge_sample   (s_edge_sample)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Async reset pulse between clocks; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, ".index"},  64'(o_index), 64'd0);
    chk({tag, ".wrap"},   64'(o_index_wrap), 64'd0);
    chk({tag, ".ev"},     64'(o_edge_valid), 64'd0);
    chk({tag, ".ei"},     64'(o_edge_index), 64'd0);
    chk({tag, ".es"},     64'(o_edge_sample), 64'd0);
    chk({tag, ".idx16"},  64'(s_index), 64'd0);
    chk({tag, ".wrap16"}, 64'(s_index_wrap), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle, record what it should produce, then compare after the edge.
  task automatic step(input logic clr, input logic stb, input logic [15:0] w,
                      input logic sel16, input logic [47:0] idx, input logic wrap,
                      input logic ev, input logic [47:0] ei, input logic [15:0] es,
                      input string tag);
    exp_t e;
    @(negedge clk);
    i_clear = clr;
    i_sample_strobe = stb;
    i_sample = w;
    sb.push_back('{sel16, idx, wrap, ev, ei, es, tag});
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    i_sample_strobe = 1'b0;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel16) begin
        chk({e.tag, ".idx16"},  64'(s_index), 64'(e.idx[15:0]));
        chk({e.tag, ".wrap16"}, 64'(s_index_wrap), 64'(e.wrap));
      end else begin
        chk({e.tag, ".index"}, 64'(o_index), 64'(e.idx));
        chk({e.tag, ".wrap"},  64'(o_index_wrap), 64'(e.wrap));
        chk({e.tag, ".ev"},    64'(o_edge_valid), 64'(e.ev));
        chk({e.tag, ".ei"},    64'(o_edge_index), 64'(e.ei));
        chk({e.tag, ".es"},    64'(o_edge_sample), 64'(e.es));
      end
    end
  endtask

  initial begin
    do_reset("rst0");

    // Defaults, mask 0: literal changes must never report an edge.
    i_edge_mask = 16'h0000;
    step(0, 1, 16'h0001, 0, 48'd1, 0, 0, 48'd0, 16'h0, "def1");
    step(0, 1, 16'h0002, 0, 48'd2, 0, 0, 48'd0, 16'h0, "def2");
    step(0, 1, 16'h0002, 0, 48'd3, 0, 0, 48'd0, 16'h0, "def3");
    step(0, 1, 16'h0005, 0, 48'd8, 0, 0, 48'd0, 16'h0, "def4");
    step(0, 1, 16'h0003, 0, 48'd9, 0, 0, 48'd0, 16'h0, "def5");
    step(0, 0, 16'h0003, 0, 48'd9, 0, 0, 48'd0, 16'h0, "defidle");

    // Escape run; final 0x0007 lands in LIT_FIRST.
    do_reset("rst1");
    step(0, 1, 16'h0007, 0, 48'd1,     0, 0, 48'd0, 16'h0, "esc1");
    step(0, 1, 16'h0007, 0, 48'd2,     0, 0, 48'd0, 16'h0, "esc2");
    step(0, 1, 16'hFFFF, 0, 48'd65537, 0, 0, 48'd0, 16'h0, "esc3");
    step(0, 1, 16'h0002, 0, 48'd65539, 0, 0, 48'd0, 16'h0, "esc4");
    step(0, 1, 16'h0007, 0, 48'd65540, 0, 0, 48'd0, 16'h0, "esc5");
    step(0, 1, 16'h0007, 0, 48'd65541, 0, 0, 48'd0, 16'h0, "esc6");

    // Edges on bit 0.
    do_reset("rst2");
    i_edge_mask = 16'h0001;
    step(0, 1, 16'h0000, 0, 48'd1, 0, 0, 48'd0, 16'h0000, "edg1");
    step(0, 1, 16'h0001, 0, 48'd2, 0, 1, 48'd1, 16'h0001, "edg2");
    step(0, 1, 16'h0003, 0, 48'd3, 0, 0, 48'd1, 16'h0001, "edg3");
    step(0, 1, 16'h0002, 0, 48'd4, 0, 1, 48'd3, 16'h0002, "edg4");
    step(0, 0, 16'h0000, 0, 48'd4, 0, 0, 48'd3, 16'h0002, "edgidle");

    // Edge across a run.
    do_reset("rst3");
    i_edge_mask = 16'h0004;
    step(0, 1, 16'h0004, 0, 48'd1, 0, 0, 48'd0, 16'h0, "run1");
    step(0, 1, 16'h0004, 0, 48'd2, 0, 0, 48'd0, 16'h0, "run2");
    step(0, 1, 16'h0003, 0, 48'd5, 0, 0, 48'd0, 16'h0, "run3");
    step(0, 1, 16'h0000, 0, 48'd6, 0, 1, 48'd5, 16'h0, "run4");

    // Wrap on the 16-bit index instance.
    do_reset("rst4");
    i_edge_mask = 16'h0000;
    step(0, 1, 16'h0001, 1, 48'd1, 0, 0, 48'd0, 16'h0, "wrap1");
    step(0, 1, 16'h0001, 1, 48'd2, 0, 0, 48'd0, 16'h0, "wrap2");
    step(0, 1, 16'hFFFF, 1, 48'd1, 1, 0, 48'd0, 16'h0, "wrap3");
    step(0, 1, 16'h0001, 1, 48'd2, 1, 0, 48'd0, 16'h0, "wrap4");
    step(0, 1, 16'h0009, 1, 48'd3, 1, 0, 48'd0, 16'h0, "wrap5");

    // Clear during a RUN count word: word dropped, edge state forgotten.
    do_reset("rst5");
    i_edge_mask = 16'h0004;
    step(0, 1, 16'h0000, 0, 48'd1, 0, 0, 48'd0, 16'h0000, "clr1");
    step(0, 1, 16'h0004, 0, 48'd2, 0, 1, 48'd1, 16'h0004, "clr2");
    step(0, 1, 16'h0004, 0, 48'd3, 0, 0, 48'd1, 16'h0004, "clr3");
    step(1, 1, 16'h0003, 0, 48'd0, 0, 0, 48'd0, 16'h0000, "clr4");
    step(0, 1, 16'h0000, 0, 48'd1, 0, 0, 48'd0, 16'h0000, "clr5");
    step(0, 1, 16'h0004, 0, 48'd2, 0, 1, 48'd1, 16'h0004, "clr6");

    // Async reset mid-stream, then restart as a literal.
    do_reset("rst6");
    step(0, 1, 16'h0004, 0, 48'd1, 0, 0, 48'd0, 16'h0, "post1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_index_decoder.md
Name: rle_index_decoder

Overview:
- Parametrised successor to the 16-bit index scanner on the capture path.
- Consumes the run-length-compressed sample word stream and keeps the absolute sample index, i.e. the count of expanded samples so far.
- Adds three things the scanner lacks: configurable sample/index widths, masked edge detection that reports the index and value of each change, and a synchronous clear plus a sticky wrap flag.
- Sits between the sample FIFO read side and the trigger/timestamp logic.

Parameters:
- SAMPLE_W, 16: width of one stream word (literal sample or run count).
- INDEX_W, 48: width of index and edge_index counters; must be >= SAMPLE_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous restart; higher priority than sample_strobe
- sample  in  SAMPLE_W  stream word, valid when sample_strobe=1
- sample_strobe  in  1  one word accepted per cycle it is high
- edge_mask  in  SAMPLE_W  bits that participate in edge detection; quasi-static
- index  out  INDEX_W  expanded-sample count after the last accepted word
- index_wrap  out  1  sticky; set on carry out of index
- edge_valid  out  1  one-cycle pulse, a masked change was detected
- edge_index  out  INDEX_W  index of the sample at which the change occurred
- edge_sample  out  SAMPLE_W  full literal value that caused the edge

Behaviour:
- Reset (rst_n=0, async) and clear=1 (sync) have the same effect:
  - index=0, index_wrap=0, state=LIT_FIRST, have_prev=0.
  - edge_valid=0; edge_index=0; edge_sample=0.
  - last_word and last_lit are don't-care.
- Word classes per state. Only cycles with sample_strobe=1 and clear=0 advance; all others hold every register.
- LIT_FIRST: word is a literal.
  - index <= index+1.
  - Next state LIT; no run check.
- LIT: word is a literal.
  - index <= index+1.
  - If sample == last_word, go to RUN; else stay in LIT.
- RUN: word is a count c.
  - index <= index + zero_extend(c).
  - If c == all-ones, stay in RUN (escape, run continues); else go to LIT_FIRST.
  - A count word never updates last_lit and never produces an edge.
- State encoding: LIT_FIRST=2'b00, LIT=2'b01, RUN=2'b10. Illegal 2'b11 goes to LIT_FIRST on the next strobe with index += 1, treating the word as a literal.
- last_word <= sample on every accepted word.
- Arithmetic: index addition is modulo 2^INDEX_W. On carry out, set index_wrap=1; it stays set until reset or clear.
- Edge detection on literals only:
  - Condition: have_prev=1 and ((sample ^ last_lit) & edge_mask) != 0.
  - On edge: edge_valid=1 in the cycle after the strobe; edge_index = index before the increment (0-based position of this sample); edge_sample = sample.
  - Every accepted literal sets last_lit <= sample and have_prev <= 1.
  - edge_valid is 0 in every other cycle. edge_index and edge_sample hold their last values.
- Latency: index, index_wrap and the edge outputs are registered. All update on the clock edge that accepts the word.
- Simultaneous clear and sample_strobe: clear wins and the word is dropped.
- Reset mid-run: the decoder restarts in LIT_FIRST. The next word is treated as a literal, and the upstream must restart the stream.
- edge_mask = 0 means edge_valid never asserts.

Decomposition:
- Package rle_index_pkg holds:
  - state typedef/constants ST_LIT_FIRST, ST_LIT, ST_RUN;
  - function is_escape(word), true when word == all-ones.
- Sub-module sample_edge_detect (parameter SAMPLE_W) is natural. It holds last_lit and have_prev, computes the masked compare, and registers the edge outputs; the parent feeds it the pre-increment index.
- The top module owns the FSM, index adder and wrap flag.

Test Plan:
- Defaults. Words 0x0001, 0x0002, 0x0002, 0x0005, 0x0003 -> index 1, 2, 3, 8, 9; state ends in LIT.
- Escape run. Words 0x0007, 0x0007, 0xFFFF, 0x0002, then 0x0007 -> index 1, 2, 65537, 65539, 65540. The final 0x0007 does not enter RUN because it arrives in LIT_FIRST.
- Edges, edge_mask=0x0001. Literals 0x0000, 0x0001, 0x0003, 0x0002 -> edge_valid at the 2nd literal (edge_index=1, edge_sample=0x0001) and at the 4th (edge_index=3, edge_sample=0x0002). No edge at the 1st or 3rd.
- Edge across a run. Literals 0x0004, 0x0004, count 0x0003, literal 0x0000 with mask 0x0004 -> edge_index=5, edge_sample=0x0000; count words produce no edge.
- Wrap, INDEX_W=16. Words 0x0001, 0x0001, 0xFFFF, 0x0001 -> index 1, 2, 0x0001, 0x0002 (2+0xFFFF = 0x10001 wraps to 0x0001); index_wrap=1 from the 3rd word, sticky.
- Clear/reset mid-run.
  - Clear asserted in the same cycle as a RUN count word -> index=0, word ignored, no edge; the next word is a literal giving index=1.
  - Async rst_n pulse between clocks -> all outputs 0 immediately.
